// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// default sizes, the writeback request record and an index-width helper.
package rf_pkg;

    localparam int RF_NREQ       = 3;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NREQ-wide request in, one-hot grant out.
// Priority starts at ptr and ascends with wrap; ptr moves past the
// winner whenever a grant is issued and holds otherwise.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int  NREQ = RF_NREQ,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_grant
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   scan;
    logic [IDW-1:0] idx;

    // Scan requesters from ptr upward with wrap; first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        scan      = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            idx = scan[IDW-1:0];
            if (en && !any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
        end
    end

    // Advance the priority pointer past the winner on every accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (any_grant) begin
            if (grant_idx == IDW'(NREQ-1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + IDW'(1);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: NREQ requesters share one write port.
// Grants are combinational (round-robin); the write itself is registered
// and issues the cycle after the transfer. Writes to x0 are accepted and
// dropped. Optional read-port bypass compare is compiled in with the
// macro RF_WB_ARB_BYPASS_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int  NREQ       = RF_NREQ,
    parameter int  ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int  DATA_WIDTH = RF_DATA_WIDTH,
    localparam int IDW        = id_width(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       hold,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [IDW-1:0]             grant_id
`ifdef RF_WB_ARB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]      byp_raddr1,
    input  logic [ADDR_WIDTH-1:0]      byp_raddr2,
    output logic                       byp_hit1,
    output logic                       byp_hit2
`endif
);

    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_idx;
    logic                  any_grant;
    logic                  arb_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grants are blocked by hold and forced off while reset is asserted.
    assign arb_en    = rst & ~hold;
    assign req_ready = grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // One-hot select of the winning requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Register the accepted write; x0 targets still update addr/data/id but never enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else if (any_grant) begin
            rf_wen   <= |sel_addr;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            grant_id <= grant_idx;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef RF_WB_ARB_BYPASS_EN
    // Readers take rf_wdata when their address matches the write issuing now.
    assign byp_hit1 = rf_wen && (rf_waddr == byp_raddr1);
    assign byp_hit2 = rf_wen && (rf_waddr == byp_raddr2);
`endif

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of writeback requesters sharing the register-file write port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hold  input  1  when 1, block all grants.
REQ-007 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-008 SHALL have port req_ready  output  NREQ  per-requester grant/accept, combinational.
REQ-009 SHALL have port req_addr  input  NREQ*ADDR_WIDTH  packed destination addresses, requester i at slice i.
REQ-010 SHALL have port req_data  input  NREQ*DATA_WIDTH  packed write data, requester i at slice i.
REQ-011 SHALL have port rf_wen  output  1  register-file write enable.
REQ-012 SHALL have port rf_waddr  output  ADDR_WIDTH  register-file write address.
REQ-013 SHALL have port rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 SHALL have port grant_id  output  $clog2(NREQ)  index of requester owning the current rf write.

Function
REQ-015 Transfer on requester i SHALL occur in a cycle where req_valid[i] && req_ready[i].
REQ-016 At most one req_ready bit SHALL be 1 per cycle; req_ready SHALL be all-zero when hold=1 or no req_valid is set.
REQ-017 Arbitration SHALL be round-robin: priority starts at index ptr, ascending with wrap from NREQ-1 to 0.
REQ-018 After a transfer from requester i, ptr SHALL become (i+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-019 req_ready SHALL NOT depend on req_addr or req_data.
REQ-020 Output stage SHALL be registered: transfer at edge t drives rf_waddr/rf_wdata/grant_id during cycle t+1.
REQ-021 rf_wen SHALL be 1 during cycle t+1 only if transfer at t and its address is nonzero; x0 writes SHALL be accepted and discarded.
REQ-022 Without a transfer, rf_wen SHALL be 0 next cycle; rf_waddr, rf_wdata and grant_id SHALL hold their last values.
REQ-023 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-024 hold asserted mid-stream SHALL not cancel an already-registered write; that write completes in the following cycle.

Reset
REQ-025 While rst=0: rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0, ptr=0, req_ready=0.
REQ-026 Reset assertion mid-operation SHALL discard any registered pending write asynchronously; no write SHALL issue after reset release until a new transfer.
REQ-027 First grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-028 Macro RF_WB_ARB_BYPASS_EN SHALL compile in bypass ports byp_raddr1/byp_raddr2 (input, ADDR_WIDTH) and byp_hit1/byp_hit2 (output, 1).
REQ-029 With RF_WB_ARB_BYPASS_EN: byp_hitN SHALL equal rf_wen && (rf_waddr==byp_raddrN), combinational; consumers take rf_wdata on hit.
REQ-030 Without RF_WB_ARB_BYPASS_EN, the bypass ports and logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package rf_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH/NREQ defaults and typedef wb_req_t {addr, data}.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (NREQ-wide req in, one-hot grant out, ptr update on accept).

Verification
REQ-033 Reset, then req_valid=3'b001, addr=5, data=0xAA -> req_ready=001 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xAA, grant_id=0.
REQ-034 All three valid continuously for 6 cycles, ptr=0 -> grant order 0,1,2,0,1,2; rf_wen=1 six consecutive cycles.
REQ-035 Requester 1 valid with addr=0, data=0x55 -> req_ready[1]=1; next cycle rf_wen=0, grant_id=1.
REQ-036 hold=1 with all valid for 3 cycles -> req_ready=000, rf_wen=0 after the pending write drains; ptr unchanged.
REQ-037 rst pulsed low in the cycle after a transfer to addr 7 -> rf_wen=0 immediately, no write to 7 after release.
REQ-038 With RF_WB_ARB_BYPASS_EN: write addr 9 issuing, byp_raddr1=9, byp_raddr2=0 -> byp_hit1=1, byp_hit2=0.
